// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin priority arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (used by rr_priority_arbiter).
package arb_pkg;

   // Upper bound on requester count supported by the one-hot helper.
   localparam int unsigned ARB_MAX_N = 64;

   localparam logic [ARB_MAX_N-1:0] ARB_ONE = {{(ARB_MAX_N-1){1'b0}}, 1'b1};

   // Arbiter control states.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Index to one-hot conversion; callers take the low N bits.
   function automatic logic [ARB_MAX_N-1:0] arb_onehot(input int unsigned idx);
      logic [ARB_MAX_N-1:0] v;
      if (idx < ARB_MAX_N) begin
         v = ARB_ONE << idx;
      end else begin
         v = '0;
      end
      return v;
   endfunction

endpackage : arb_pkg

// File: rtl/prio_enc_n.sv
// Combinational highest-index-wins priority encoder over N inputs.
module prio_enc_n #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   // Scan upward so the highest set bit is the last (winning) assignment.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i]) begin
            idx_o   = W'(i);
            valid_o = 1'b1;
         end else begin
            idx_o   = idx_o;
            valid_o = valid_o;
         end
      end
   end

endmodule : prio_enc_n

// File: rtl/rr_priority_arbiter.sv
// N-requester arbiter: registered grant held until ack, highest index wins.
// Build macro ARB_ROUND_ROBIN_EN: when defined, the last winner becomes the
// lowest priority on ack (rotating priority); when undefined the search
// pointer stays at 0 (fixed priority). Ports are identical in both builds.
module rr_priority_arbiter
   import arb_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_onehot
);

   localparam logic [W:0] N_L = (W+1)'(N);

   arb_state_e   state_q, state_d;
   logic [W-1:0] last_ptr_q, last_ptr_d;
   logic         grant_valid_q, grant_valid_d;
   logic [W-1:0] grant_idx_q, grant_idx_d;
   logic [N-1:0] grant_onehot_q, grant_onehot_d;

   logic [N-1:0] rot_req_s;
   logic [W-1:0] enc_idx_s;
   logic         enc_valid_s;
   logic [W:0]   sum_s;
   logic [W-1:0] win_idx_s;

   // Rotate requests so bit last_ptr-1 sits at the top of the encoder input.
   always_comb begin
      rot_req_s = N'({req, req} >> last_ptr_q);
   end

   prio_enc_n #(.N(N)) u_enc (
      .req_i   (rot_req_s),
      .idx_o   (enc_idx_s),
      .valid_o (enc_valid_s)
   );

   // Map the encoder result back to a requester index (add last_ptr mod N).
   always_comb begin
      sum_s = {1'b0, enc_idx_s} + {1'b0, last_ptr_q};
      if (sum_s >= N_L) begin
         win_idx_s = W'(sum_s - N_L);
      end else begin
         win_idx_s = W'(sum_s);
      end
   end

   // Next-state logic: grant on any request from IDLE, release on ack.
   always_comb begin
      state_d        = state_q;
      last_ptr_d     = last_ptr_q;
      grant_valid_d  = grant_valid_q;
      grant_idx_d    = grant_idx_q;
      grant_onehot_d = grant_onehot_q;
      case (state_q)
         IDLE: begin
            if (enc_valid_s) begin
               state_d        = GRANT;
               grant_valid_d  = 1'b1;
               grant_idx_d    = win_idx_s;
               grant_onehot_d = N'(arb_onehot(32'(win_idx_s)));
            end else begin
               grant_valid_d  = 1'b0;
               grant_idx_d    = '0;
               grant_onehot_d = '0;
            end
         end
         GRANT: begin
            if (ack) begin
               state_d        = IDLE;
               grant_valid_d  = 1'b0;
               grant_idx_d    = '0;
               grant_onehot_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
               last_ptr_d     = grant_idx_q;
`else
               last_ptr_d     = '0;
`endif
            end else begin
               state_d        = GRANT;
            end
         end
         default: begin
            state_d        = IDLE;
            last_ptr_d     = '0;
            grant_valid_d  = 1'b0;
            grant_idx_d    = '0;
            grant_onehot_d = '0;
         end
      endcase
   end

   // State, pointer and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         last_ptr_q     <= '0;
         grant_valid_q  <= 1'b0;
         grant_idx_q    <= '0;
         grant_onehot_q <= '0;
      end else begin
         state_q        <= state_d;
         last_ptr_q     <= last_ptr_d;
         grant_valid_q  <= grant_valid_d;
         grant_idx_q    <= grant_idx_d;
         grant_onehot_q <= grant_onehot_d;
      end
   end

   assign grant_valid  = grant_valid_q;
   assign grant_idx    = grant_idx_q;
   assign grant_onehot = grant_onehot_q;

endmodule : rr_priority_arbiter
